// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Memory/MMIO responder for a small 16-bit CPU, with a streaming program
//   loader that holds the CPU in reset while it fills RAM.
//
//   Address map (word addresses):
//     addr < DEPTH   RAM, read/write
//     MMIO_BASE+0    buttons, synchronized (read only)
//     MMIO_BASE+1    LED register, 10 bits (read/write)
//     MMIO_BASE+2    free-running cycle counter (read only)
//     MMIO_BASE+3    button press latch (reading it clears it)
//     anything else  reads 0, writes ignored
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     addr, write_en,       CPU bus; data_out is registered one cycle
//     data_in, data_out     after addr and is write-first on a write
//     buttons, leds         board I/O
//     load_start, load_valid,
//     load_data, load_last,
//     load_ready            program loader stream (valid/ready)
//     cpu_reset             holds the CPU in reset during reset/load/flush
//
//   state | meaning
//   IDLE  | normal CPU bus service
//   LOAD  | accepting loader words into RAM, CPU held in reset
//   FLUSH | two-cycle settle after the load before releasing the CPU
module mem_bus_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        write_en,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic [3:0]  buttons,
    output logic [9:0]  leds,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        cpu_reset
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U  = DEPTH;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    localparam logic [15:0] ADDR_BTN   = MMIO_BASE;
    localparam logic [15:0] ADDR_LEDS  = MMIO_BASE + 16'd1;
    localparam logic [15:0] ADDR_CNT   = MMIO_BASE + 16'd2;
    localparam logic [15:0] ADDR_PRESS = MMIO_BASE + 16'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    logic [15:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          flush_q, flush_d;
    logic [15:0]   data_out_q, data_out_d;
    logic [9:0]    leds_q, leds_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [3:0]    press_q, press_d;
    logic [3:0]    sync1_q, sync2_q, sync3_q;
    logic          load_ready_q, load_ready_d;

    logic          is_ram;
    logic [15:0]   rd_val;
    logic [3:0]    rise;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;

    assign is_ram = ({16'b0, addr} < DEPTH_U);
    assign rise   = sync2_q & ~sync3_q;

    always_comb begin
        rd_val = 16'h0000;
        if (is_ram) begin
            rd_val = mem[addr[AW-1:0]];
        end else begin
            case (addr)
                ADDR_BTN:   rd_val = {12'b0, sync2_q};
                ADDR_LEDS:  rd_val = {6'b0, leds_q};
                ADDR_CNT:   rd_val = cnt_q;
                ADDR_PRESS: rd_val = {12'b0, press_q};
                default:    rd_val = 16'h0000;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        flush_d    = flush_q;
        data_out_d = 16'h0000;
        leds_d     = leds_q;
        cnt_d      = cnt_q + 16'd1;
        press_d    = press_q | rise;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = 16'h0000;

        case (state_q)
            IDLE: begin
                if (write_en) begin
                    data_out_d = data_in;
                    if (is_ram) begin
                        ram_we    = 1'b1;
                        ram_addr  = addr[AW-1:0];
                        ram_wdata = data_in;
                    end else if (addr == ADDR_LEDS) begin
                        leds_d = data_in[9:0];
                    end
                end else begin
                    data_out_d = rd_val;
                    // Clear-on-read loses to a new edge in the same cycle.
                    if (!is_ram && addr == ADDR_PRESS) begin
                        press_d = rise;
                    end
                end
                if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                if (load_valid && load_ready_q) begin
                    ram_we    = 1'b1;
                    ram_addr  = ptr_q;
                    ram_wdata = load_data;
                    // Stop at the last RAM word rather than wrapping onto word 0.
                    if (load_last || ptr_q == LAST_PTR) begin
                        ptr_d   = '0;
                        state_d = FLUSH;
                        flush_d = 1'b0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (flush_q) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                end else begin
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        load_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            flush_q      <= 1'b0;
            data_out_q   <= 16'h0000;
            leds_q       <= 10'h000;
            cnt_q        <= 16'h0000;
            press_q      <= 4'h0;
            sync1_q      <= 4'h0;
            sync2_q      <= 4'h0;
            sync3_q      <= 4'h0;
            load_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            flush_q      <= flush_d;
            data_out_q   <= data_out_d;
            leds_q       <= leds_d;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
            sync1_q      <= buttons;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            load_ready_q <= load_ready_d;
        end
    end

    // RAM has no reset so a program survives a CPU/board reset.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    assign data_out   = data_out_q;
    assign leds       = leds_q;
    assign load_ready = load_ready_q;
    assign cpu_reset  = reset | (state_q != IDLE);

endmodule
